caesar_ciphertext_collector: RTL and testbench

Downstream stage of the three-stage Caesar cipher core. Each cycle it samples the core's registered outputs (ciphertext char, ready flag, error flags) and buffers valid ciphertext characters in a first-word-fall-through FIFO. It presents the characters to the consumer over a valid/ready handshake. It also keeps saturating error statistics and a sticky overflow flag for the system controller.

---
 rtl/caesar_ciphertext_collector_if.sv | 10 +
 rtl/caesar_ciphertext_collector.sv | 92 +++++++++
 tb/tb_caesar_ciphertext_collector.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/caesar_ciphertext_collector_if.sv
// Consumer-side character stream of the ciphertext collector.
// The collector drives the character and its valid flag; the consumer drives ready.
interface caesar_ciphertext_collector_if;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_char, output out_valid, input out_ready);
    modport slave  (input out_char, input out_valid, output out_ready);
endinterface

// File: rtl/caesar_ciphertext_collector.sv
// Collects ciphertext characters from the Caesar cipher core.
// Characters are buffered in a first-word-fall-through FIFO and handed to a
// valid/ready consumer. The block also keeps saturating error counters and a
// sticky overflow flag.
module caesar_ciphertext_collector #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           ciphertext_char,
    input  logic                 flag_ciphertext_ready,
    input  logic                 err_invalid_key_shift_num,
    input  logic                 err_invalid_ptxt_char,
    input  logic                 clear_stats,
    caesar_ciphertext_collector_if.master out_if,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 flag_fifo_full,
    output logic                 flag_overflow,
    output logic [CNT_W-1:0]     key_err_count,
    output logic [CNT_W-1:0]     char_err_count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop;
    logic             push;
    logic             drop;

    // A slot freed by a pop can be refilled in the same cycle, so a full FIFO
    // that is being drained never drops.
    always_comb begin
        flag_fifo_full   = (fifo_level == LVL_W'(DEPTH));
        out_if.out_valid = (fifo_level != '0);
        out_if.out_char  = out_if.out_valid ? mem[rd_ptr] : 8'h00;
        pop              = out_if.out_valid && out_if.out_ready;
        push             = flag_ciphertext_ready && (!flag_fifo_full || pop);
        drop             = flag_ciphertext_ready && flag_fifo_full && !pop;
    end

    // Storage has no reset; contents only become visible through fifo_level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ciphertext_char;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
            else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
        end
    end

    // Sticky overflow; a clear in the same cycle as a drop wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_overflow <= 1'b0;
        end else if (clear_stats) begin
            flag_overflow <= 1'b0;
        end else if (drop) begin
            flag_overflow <= 1'b1;
        end
    end

    // Independent saturating error counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_err_count  <= '0;
            char_err_count <= '0;
        end else if (clear_stats) begin
            key_err_count  <= '0;
            char_err_count <= '0;
        end else begin
            if (err_invalid_key_shift_num && !(&key_err_count))
                key_err_count <= key_err_count + CNT_W'(1);
            if (err_invalid_ptxt_char && !(&char_err_count))
                char_err_count <= char_err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_caesar_ciphertext_collector.sv
// Scoreboard bench for the ciphertext collector (DEPTH=16, CNT_W=4).
// Accepted characters are queued when driven; a negedge monitor pops and
// compares every character the DUT hands over.
module tb_caesar_ciphertext_collector;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       ciphertext_char = 8'h00;
    logic             flag_ciphertext_ready = 1'b0;
    logic             err_invalid_key_shift_num = 1'b0;
    logic             err_invalid_ptxt_char = 1'b0;
    logic             clear_stats = 1'b0;
    logic [LVL_W-1:0] fifo_level;
    logic             flag_fifo_full;
    logic             flag_overflow;
    logic [CNT_W-1:0] key_err_count;
    logic [CNT_W-1:0] char_err_count;

    caesar_ciphertext_collector_if out_if ();

    caesar_ciphertext_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .ciphertext_char           (ciphertext_char),
        .flag_ciphertext_ready     (flag_ciphertext_ready),
        .err_invalid_key_shift_num (err_invalid_key_shift_num),
        .err_invalid_ptxt_char     (err_invalid_ptxt_char),
        .clear_stats               (clear_stats),
        .out_if                    (out_if.master),
        .fifo_level                (fifo_level),
        .flag_fifo_full            (flag_fifo_full),
        .flag_overflow             (flag_overflow),
        .key_err_count             (key_err_count),
        .char_err_count            (char_err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb_q[$];

    // Model state predicted for the next cycle.
    int m_lvl = 0;
    int m_ovf = 0;
    int m_key = 0;
    int m_chr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every handshake must deliver the oldest outstanding character.
    always @(negedge clk) begin
        if (rst_n && out_if.out_valid && out_if.out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got 0x%0h expected no output", out_if.out_char);
            end else begin
                logic [7:0] exp_c;
                exp_c = sb_q.pop_front();
                if (out_if.out_char !== exp_c) begin
                    failures++;
                    $display("FAIL pop_char: got 0x%0h expected 0x%0h at %0t", out_if.out_char, exp_c, $time);
                end
            end
        end
    end

    // Entered at posedge+1: check settled outputs, drive the next cycle, advance model.
    task automatic step(input logic v, input logic [7:0] c, input logic rdy,
                        input logic ke, input logic ce, input logic clr);
        bit full, pop, push, drop;
        chk("level", int'(fifo_level), m_lvl);
        chk("valid", int'(out_if.out_valid), int'(m_lvl != 0));
        chk("full", int'(flag_fifo_full), int'(m_lvl == DEPTH));
        chk("overflow", int'(flag_overflow), m_ovf);
        chk("key_cnt", int'(key_err_count), m_key);
        chk("char_cnt", int'(char_err_count), m_chr);
        if (m_lvl == 0) begin
            chk("char_idle", int'(out_if.out_char), 0);
        end else if (sb_q.size() == 0) begin
            chk("head_missing", 0, 1);
        end else begin
            chk("head", int'(out_if.out_char), int'(sb_q[0]));
        end

        flag_ciphertext_ready     = v;
        ciphertext_char           = c;
        out_if.out_ready          = rdy;
        err_invalid_key_shift_num = ke;
        err_invalid_ptxt_char     = ce;
        clear_stats               = clr;

        full = (m_lvl == DEPTH);
        pop  = (m_lvl > 0) && rdy;
        push = v && (!full || pop);
        drop = v && full && !pop;
        if (push) sb_q.push_back(c);
        m_lvl = m_lvl + int'(push) - int'(pop);
        if (clr) begin
            m_ovf = 0; m_key = 0; m_chr = 0;
        end else begin
            if (drop) m_ovf = 1;
            if (ke && m_key < 15) m_key++;
            if (ce && m_chr < 15) m_chr++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 8'h00, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] kho [3] = '{8'h4B, 8'h48, 8'h4F};

    initial begin
        out_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, then K,H,O with consumer stalled.
        chk("rst_valid", int'(out_if.out_valid), 0);
        chk("rst_char", int'(out_if.out_char), 0);
        for (int i = 0; i < 3; i++) step(1'b1, kho[i], 1'b0, 1'b0, 1'b0, 1'b0);
        chk("kho_level", int'(fifo_level), 3);
        chk("kho_head", int'(out_if.out_char), 8'h4B);
        idle(1'b0);
        chk("kho_head_hold", int'(out_if.out_char), 8'h4B);
        repeat (4) idle(1'b1);

        // 17 pushes into a stalled FIFO: the last one is dropped.
        for (int i = 0; i < 17; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fill_full", int'(flag_fifo_full), 1);
        chk("fill_ovf", int'(flag_overflow), 1);
        chk("fill_level", int'(fifo_level), 16);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full FIFO streaming with pop and push each cycle: no drops.
        for (int i = 0; i < 20; i++) step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stream_ovf", int'(flag_overflow), 0);
        chk("stream_level", int'(fifo_level), 16);
        repeat (17) idle(1'b1);

        // Error counting: key 5 cycles, char 3 cycles, overlapping 2.
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, i < 5, i >= 3, 1'b0);
        chk("key_cnt5", int'(key_err_count), 5);
        chk("char_cnt3", int'(char_err_count), 3);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("key_clear", int'(key_err_count), 0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("char_sat", int'(char_err_count), 15);
        idle(1'b0);

        // Reset with 5 chars buffered.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_if.out_valid), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_char", int'(out_if.out_char), 0);
        chk("mid_rst_chrcnt", int'(char_err_count), 0);
        sb_q.delete();
        m_lvl = 0; m_ovf = 0; m_key = 0; m_chr = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_char", int'(out_if.out_char), 8'h41);
        chk("post_rst_level", int'(fifo_level), 1);
        repeat (3) idle(1'b1);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
